// File: rtl/det_pkg.sv
// Shared types and constants for the 3x3 determinant sequencer.
package det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Operation performed by the shared multiplier/adder in a given step
  typedef enum logic [1:0] {
    OP_MUL_T,    // t   <= p*q
    OP_MSUB_T,   // t   <= t - r*s
    OP_ACC_ADD,  // acc <= acc + coef*t
    OP_ACC_SUB   // acc <= acc - coef*t
  } op_e;

  localparam int unsigned NSTEPS = 9;

  localparam int unsigned A_IDX = 0;
  localparam int unsigned B_IDX = 1;
  localparam int unsigned C_IDX = 2;
  localparam int unsigned D_IDX = 3;
  localparam int unsigned E_IDX = 4;
  localparam int unsigned F_IDX = 5;
  localparam int unsigned G_IDX = 6;
  localparam int unsigned H_IDX = 7;
  localparam int unsigned I_IDX = 8;

  // Bit k set: cofactor term k is subtracted from the accumulator
  localparam logic [2:0] TERM_NEG = 3'b010;

  function automatic logic is_last_step(input logic [3:0] step);
    return step == 4'(NSTEPS - 1);
  endfunction

  function automatic op_e acc_op(input logic neg);
    return neg ? OP_ACC_SUB : OP_ACC_ADD;
  endfunction

endpackage

// File: rtl/det_operand_mux.sv
// Maps the schedule step to the shared multiplier operands and add/sub select.
module det_operand_mux
  import det_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [3:0]      step_i,
  input  logic [9*DW-1:0] m_i,
  input  logic [DW-1:0]   t_i,
  output logic [DW-1:0]   op_a_o,
  output logic [DW-1:0]   op_b_o,
  output op_e             op_sel_o
);

  logic [DW-1:0] el [9];

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      el[i] = m_i[DW*i +: DW];
    end
  end

  // Three steps per term: first minor product, subtract second, scale by coef
  always_comb begin
    op_a_o   = '0;
    op_b_o   = '0;
    op_sel_o = OP_MUL_T;
    case (step_i)
      4'd0: begin op_a_o = el[E_IDX]; op_b_o = el[I_IDX]; op_sel_o = OP_MUL_T;  end
      4'd1: begin op_a_o = el[F_IDX]; op_b_o = el[H_IDX]; op_sel_o = OP_MSUB_T; end
      4'd2: begin op_a_o = el[A_IDX]; op_b_o = t_i;       op_sel_o = acc_op(TERM_NEG[0]); end
      4'd3: begin op_a_o = el[D_IDX]; op_b_o = el[I_IDX]; op_sel_o = OP_MUL_T;  end
      4'd4: begin op_a_o = el[F_IDX]; op_b_o = el[G_IDX]; op_sel_o = OP_MSUB_T; end
      4'd5: begin op_a_o = el[B_IDX]; op_b_o = t_i;       op_sel_o = acc_op(TERM_NEG[1]); end
      4'd6: begin op_a_o = el[D_IDX]; op_b_o = el[H_IDX]; op_sel_o = OP_MUL_T;  end
      4'd7: begin op_a_o = el[E_IDX]; op_b_o = el[G_IDX]; op_sel_o = OP_MSUB_T; end
      4'd8: begin op_a_o = el[C_IDX]; op_b_o = t_i;       op_sel_o = acc_op(TERM_NEG[2]); end
      default: begin
        op_a_o   = '0;
        op_b_o   = '0;
        op_sel_o = OP_MUL_T;
      end
    endcase
  end

endmodule

// File: rtl/det3_sequencer.sv
// 3x3 determinant sequencer: captures a matrix, runs a 9-step cofactor
// schedule on one shared multiplier and adder, returns det over valid/ready.
module det3_sequencer
  import det_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] m_flat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   det,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [9*DW-1:0] m_q, m_d;
  logic [DW-1:0]   t_q, t_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   det_q, det_d;

  logic [DW-1:0]   op_a, op_b;
  op_e             op_sel;
  logic [DW-1:0]   prod;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   sum;
  logic            do_sub;

  det_operand_mux #(
    .DW(DW)
  ) u_mux (
    .step_i   (step_q),
    .m_i      (m_q),
    .t_i      (t_q),
    .op_a_o   (op_a),
    .op_b_o   (op_b),
    .op_sel_o (op_sel)
  );

  // Shared arithmetic; results wrap modulo 2^DW
  always_comb begin
    prod   = op_a * op_b;
    add_a  = (op_sel == OP_MSUB_T) ? t_q : acc_q;
    do_sub = (op_sel == OP_MSUB_T) || (op_sel == OP_ACC_SUB);
    sum    = do_sub ? (add_a - prod) : (add_a + prod);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    m_d     = m_q;
    t_d     = t_q;
    acc_d   = acc_q;
    det_d   = det_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          m_d     = m_flat;
          t_d     = '0;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      CALC: begin
        case (op_sel)
          OP_MUL_T:  t_d   = prod;
          OP_MSUB_T: t_d   = sum;
          default:   acc_d = sum;
        endcase
        if (is_last_step(step_q)) begin
          det_d   = sum;
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      m_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      det_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      m_q     <= m_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      det_q   <= det_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign det       = det_q;

endmodule

// File: tb/tb_det3_sequencer.sv
// Directed-vector bench for det3_sequencer with hand-computed determinants.
module tb_det3_sequencer;

  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [9*DW-1:0] m_flat;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   det;
  logic            busy;

  int tot;
  int bad;

  det3_sequencer #(
    .DW(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_flat    (m_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .det       (det),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] mk(input int a, input int b, input int c,
                                         input int d, input int e, input int f,
                                         input int g, input int h, input int i);
    logic [9*DW-1:0] m;
    m = {32'(i), 32'(h), 32'(g), 32'(f), 32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture one matrix, measure latency, check det; accept if out_ready is high
  task automatic run(input logic [9*DW-1:0] m, input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    m_flat   = m;
    tick();
    in_valid = 1'b0;
    m_flat   = '0;
    chk({tag, "_busy"}, {30'd0, busy, in_ready}, 32'b10);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd9);
    chk({tag, "_det"}, det, exp);
    if (out_ready) begin
      tick();
      chk({tag, "_acc"}, {30'd0, out_valid, in_ready}, 32'b01);
    end
  endtask

  initial begin
    logic [31:0] held;
    tot       = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    m_flat    = '0;
    #12;
    chk("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst_det", det, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run(mk(1,0,0, 0,1,0, 0,0,1), 32'd1, "ident");
    run(mk(1,2,3, 4,5,6, 7,8,10), 32'hFFFF_FFFD, "m10");
    run(mk(1,2,3, 4,5,6, 7,8,9), 32'd0, "m9");
    run(mk(65536,0,0, 0,65536,0, 0,0,1), 32'd0, "wrap");
    run(mk(3,1,2, 4,-1,5, 2,6,7), 32'hFFFF_FFB3, "gen");

    // Backpressure: result held, new inputs ignored
    out_ready = 1'b0;
    run(mk(-2,0,0, 0,3,0, 0,0,5), 32'hFFFF_FFE2, "neg");
    held = det;
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      m_flat   = mk(k+2,1,1, 1,k+3,1, 1,1,k+4);
      tick();
      chk($sformatf("bp%0d_flags", k), {29'd0, in_ready, out_valid, busy}, 32'b011);
      chk($sformatf("bp%0d_det", k), det, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_accept", {29'd0, in_ready, out_valid, busy}, 32'b100);
    tick();
    chk("bp_nocap", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("bp_dethold", det, 32'hFFFF_FFE2);

    // Reset during step 4
    in_valid = 1'b1;
    m_flat   = mk(2,0,0, 0,2,0, 0,0,2);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("mrst_det", det, 32'd0);
    tick();
    tick();
    chk("mrst_hold", {29'd0, in_ready, out_valid, busy}, 32'b100);
    rst_n = 1'b1;
    tick();
    run(mk(1,0,0, 0,1,0, 0,0,1), 32'd1, "post_rst");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
